memory_arbiter: RTL
===================

# memory_arbiter

Two-core memory arbiter that shares the single RAM port among four cache requesters: icache0, icache1, dcache0 and dcache1. It sits between the per-core cache interfaces and the RAM interface. It grants one requester at a time and locks that grant for a whole dcache block transfer. Stalls are returned to each requester through its wait line.

## Interface
- BLK_WORDS, 2, words per dcache block; number of RAM accesses a dcache grant is held for
- ADDR_W, 32, address/data width (word_t)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  2  icache read request, bit = core
- dREN  in  2  dcache read request
- dWEN  in  2  dcache write request
- iaddr  in  2x32  icache addresses, per core
- daddr  in  2x32  dcache addresses, per core
- dstore  in  2x32  dcache write data, per core
- iwait  out  2  icache stall, per core
- dwait  out  2  dcache stall, per core
- iload  out  32  read data to icaches (ramload, shared)
- dload  out  32  read data to dcaches (ramload, shared)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- The arbiter is an FSM with two states: IDLE and XFER. The registered owner holds a type bit (I or D) and a core bit. A word counter cnt is clog2(BLK_WORDS)+1 bits wide. rr is the round-robin core pointer.
- Priority in IDLE:
  - Any dcache request (dREN|dWEN) beats any icache request.
  - Within one class, the core is chosen by rr when both cores request; otherwise the single requester wins.
- IDLE with at least one request: latch the owner, set cnt=0, go to XFER. With no request, stay in IDLE.
- In XFER, RAM is driven from the owner's live signals:
  - dcache owner: ramaddr=daddr[c], ramstore=dstore[c].
  - dcache write takes precedence: if dWEN[c] then ramWEN=1, else ramREN=1. dREN and dWEN both high means a write.
  - icache owner: ramREN=1, ramaddr=iaddr[c].
- In XFER with ramstate==ACCESS: deassert the owner's wait in that same cycle and increment cnt.
  - An icache owner releases after 1 word.
  - A dcache owner releases once cnt reaches BLK_WORDS.
  - On release: go to IDLE and set rr = ~owner.core.
- If the owner's request drops during XFER: go to IDLE next cycle with no RAM access, and set rr = ~owner.core.
- ramstate BUSY, FREE or ERROR in XFER: the owner stays stalled and the state is held. No timeout.
- All wait outputs are 1 except the owner's wait during an ACCESS cycle. Non-owners always stall.
- iload = dload = ramload, unconditionally.

## Timing
- Reset values:
  - state=IDLE, rr=0, cnt=0, owner=D0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=2'b11, dwait=2'b11.
- Reset asserted mid-transfer aborts it. RAM enables drop asynchronously.
- Request at cycle N while IDLE: RAM is enabled at N+1. The earliest wait deassertion is N+1 if RAM returns ACCESS immediately.
- There is exactly one IDLE cycle between consecutive grants, including a dcache writeback burst followed by its load burst. The other core may win that gap.
- RAM outputs are combinational from the registered owner and state. They are 0 in IDLE.

## Configuration
- MEMARB_ROUND_ROBIN_EN defined: rr operates as described above.
- MEMARB_ROUND_ROBIN_EN undefined: rr is tied to 0, so core 0 always wins ties within a class. The dcache-over-icache rule is unchanged.

## Structure
- Add to cpu_types_pkg:
  - arbstate_t {IDLE, XFER}
  - arbowner_t (packed struct: isd, core)
  - the existing ramstate_t
- Sub-module mem_arb_select is combinational. It takes (iREN, dREN, dWEN, rr) and returns the next owner and a valid flag.
- Everything else lives in memory_arbiter.

## Test plan
- dREN[0]=1, daddr[0]=0x100, RAM gives ACCESS after 2 BUSY cycles per word -> ramaddr 0x100 then 0x104 (dcache advances), dwait[0] low for 1 cycle each time, 2 accesses, then IDLE.
- Same cycle: iREN[0]=1 and dWEN[1]=1 with dstore[1]=0xDEADBEEF -> dcache1 granted first: ramWEN=1, ramstore=0xDEADBEEF, iwait[0]=1 throughout. The icache is granted after one IDLE cycle.
- dREN=2'b11 continuously -> grants alternate core 0, core 1, core 0. Without MEMARB_ROUND_ROBIN_EN, core 0 wins every tie.
- dREN[1] drops during the BUSY phase of word 0 -> ramREN=0 the next cycle, state IDLE, dwait[1] never low.
- nRST pulsed low during XFER with ramWEN=1 -> ramWEN=0 immediately, all waits=1, state IDLE after release.
- dREN and dWEN both high on core 0 -> ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU-side types for the memory arbiter: RAM handshake state, arbiter
// FSM state, arbiter owner record and a small tie-break helper.
// No ports (package).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state as presented by the RAM controller
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM state, kept as plain constants so older code can compare
    // against raw bit values
    typedef logic [0:0] arbstate_t;
    localparam arbstate_t IDLE = 1'b0;
    localparam arbstate_t XFER = 1'b1;

    // Grant owner: isd=1 for a dcache, core selects core 0/1
    typedef struct packed {
        logic isd;
        logic core;
    } arbowner_t;

    localparam arbowner_t OWNER_D0 = '{isd: 1'b1, core: 1'b0};

    // Core chosen within one requester class: round-robin pointer on a tie,
    // otherwise the only requesting core
    function automatic logic pick_core(input logic [1:0] req, input logic rr);
        logic core_v;
        if (req == 2'b11) begin
            core_v = rr;
        end else begin
            core_v = req[1];
        end
        return core_v;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select
// Combinational grant selection for the memory arbiter.
// Ports:
//   iREN[1:0]  icache read requests, bit = core
//   dREN[1:0]  dcache read requests
//   dWEN[1:0]  dcache write requests
//   rr         round-robin core pointer used on a tie within a class
//   owner      selected owner (type + core), valid only when valid=1
//   valid      at least one request is pending
module mem_arb_select
    import cpu_types_pkg::*;
(
    input  logic [1:0] iREN,
    input  logic [1:0] dREN,
    input  logic [1:0] dWEN,
    input  logic       rr,
    output arbowner_t  owner,
    output logic       valid
);

    logic [1:0] dreq_s;

    assign dreq_s = dREN | dWEN;

    // Any dcache request beats any icache request; core tie broken by rr
    always_comb begin
        valid = (|dreq_s) | (|iREN);
        if (|dreq_s) begin
            owner = '{isd: 1'b1, core: pick_core(dreq_s, rr)};
        end else if (|iREN) begin
            owner = '{isd: 1'b0, core: pick_core(iREN, rr)};
        end else begin
            owner = OWNER_D0;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the single RAM port between icache0/1 and dcache0/1. One requester
// is granted at a time; a dcache grant is held for a whole BLK_WORDS block.
// Optional feature: define MEMARB_ROUND_ROBIN_EN to alternate cores on ties;
// when undefined core 0 always wins a tie within a class.
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   iREN/dREN/dWEN     per-core requests
//   iaddr/daddr/dstore per-core addresses and dcache write data
//   iwait/dwait        per-core stalls (1 = stall)
//   iload/dload        read data to caches (straight from ramload)
//   ramREN/ramWEN/ramaddr/ramstore  RAM request (combinational from owner)
//   ramload/ramstate   RAM read data and handshake state
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BLK_WORDS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             iREN,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][ADDR_W-1:0] iaddr,
    input  logic [1:0][ADDR_W-1:0] daddr,
    input  logic [1:0][ADDR_W-1:0] dstore,
    output logic [1:0]             iwait,
    output logic [1:0]             dwait,
    output logic [ADDR_W-1:0]      iload,
    output logic [ADDR_W-1:0]      dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [ADDR_W-1:0]      ramstore,
    input  logic [ADDR_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int CNT_W = $clog2(BLK_WORDS) + 1;

    arbstate_t  state_q, state_d;
    arbowner_t  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;

    arbowner_t  sel_owner_s;
    logic       sel_valid_s;
    logic       owner_req_s;
    logic       access_s;
    logic       rr_next_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic       blk_done_s;

    mem_arb_select u_select (
        .iREN  (iREN),
        .dREN  (dREN),
        .dWEN  (dWEN),
        .rr    (rr_q),
        .owner (sel_owner_s),
        .valid (sel_valid_s)
    );

    // Live request of the current owner; a drop ends the grant early
    assign owner_req_s = owner_q.isd ? (dREN[owner_q.core] | dWEN[owner_q.core])
                                     : iREN[owner_q.core];
    assign access_s    = (state_q == XFER) && owner_req_s && (ramstate == ACCESS);
    assign cnt_inc_s   = cnt_q + CNT_W'(1);
    assign blk_done_s  = (cnt_inc_s == CNT_W'(BLK_WORDS));

`ifdef MEMARB_ROUND_ROBIN_EN
    assign rr_next_s = ~owner_q.core;
`else
    assign rr_next_s = 1'b0;
`endif

    assign iload = ramload;
    assign dload = ramload;

    // RAM request and stalls, driven from the owner's live signals
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        if (state_q == XFER) begin
            if (owner_q.isd) begin
                ramaddr  = daddr[owner_q.core];
                ramstore = dstore[owner_q.core];
                // a write wins when both read and write are raised
                ramWEN   = dWEN[owner_q.core];
                ramREN   = dREN[owner_q.core] & ~dWEN[owner_q.core];
                if (access_s) begin
                    dwait[owner_q.core] = 1'b0;
                end else begin
                    dwait[owner_q.core] = 1'b1;
                end
            end else begin
                ramaddr = iaddr[owner_q.core];
                ramREN  = iREN[owner_q.core];
                if (access_s) begin
                    iwait[owner_q.core] = 1'b0;
                end else begin
                    iwait[owner_q.core] = 1'b1;
                end
            end
        end else begin
            ramREN = 1'b0;
            ramWEN = 1'b0;
        end
    end

    // Grant FSM next state: grant in IDLE, hold through XFER until release
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (sel_valid_s) begin
                    owner_d = sel_owner_s;
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (!owner_req_s) begin
                    state_d = IDLE;
                    rr_d    = rr_next_s;
                end else if (access_s) begin
                    cnt_d = cnt_inc_s;
                    // icache moves one word; dcache holds for a whole block
                    if (!owner_q.isd || blk_done_s) begin
                        state_d = IDLE;
                        rr_d    = rr_next_s;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= OWNER_D0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

endmodule
